// File: rtl/rx_hdr_lock_mon.sv
// 64b/66b sync-header block-lock monitor: hunts for lock via SERDES bitslip,
// tracks lock-loss events and per-window valid/invalid header statistics.
module rx_hdr_lock_mon #(
  parameter int unsigned HDR_WIDTH           = 2,
  parameter int unsigned BITSLIP_HIGH_CYCLES = 1,
  parameter int unsigned BITSLIP_LOW_CYCLES  = 8,
  parameter int unsigned WINDOW              = 500
) (
  input  logic                 rx_clk_tb,
  input  logic                 rx_rst_tb,
  input  logic                 hdr_valid,
  input  logic [HDR_WIDTH-1:0] rx_hdr,
  output logic                 bitslip,
  output logic                 block_lock,
  output logic [7:0]           lock_loss_count,
  output logic [15:0]          hdrs_to_unlock,
  output logic [15:0]          win_valid,
  output logic [15:0]          win_invalid,
  output logic                 window_done
);

  localparam logic [15:0] SlipLastCnt = 16'(BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES - 1);
  localparam logic [15:0] HighLastCnt = 16'(BITSLIP_HIGH_CYCLES - 1);
  localparam logic [16:0] WindowLen   = 17'(WINDOW);

  typedef enum logic [1:0] {
    StUnlocked,
    StSlip,
    StLocked
  } state_e;

  state_e      state_q;
  logic [6:0]  sh_cnt_q;
  logic [4:0]  inv_cnt_q;
  logic [15:0] slip_cnt_q;
  logic [15:0] since_cnt_q;
  logic        armed_q;
  logic [15:0] win_v_cnt_q;
  logic [15:0] win_i_cnt_q;

  logic        hdr_ok;
  logic [6:0]  sh_nxt;
  logic [4:0]  inv_nxt;
  logic [15:0] since_nxt;
  logic [15:0] win_v_nxt;
  logic [15:0] win_i_nxt;
  logic [16:0] win_sum;

  assign hdr_ok = (rx_hdr == HDR_WIDTH'(1)) || (rx_hdr == HDR_WIDTH'(2));

  always_comb begin
    sh_nxt    = sh_cnt_q + 7'd1;
    inv_nxt   = inv_cnt_q + {4'd0, ~hdr_ok};
    since_nxt = (since_cnt_q == 16'hFFFF) ? since_cnt_q : since_cnt_q + 16'd1;
    win_v_nxt = win_v_cnt_q + {15'd0, hdr_ok};
    win_i_nxt = win_i_cnt_q + {15'd0, ~hdr_ok};
    win_sum   = {1'b0, win_v_nxt} + {1'b0, win_i_nxt};
  end

  always_ff @(posedge rx_clk_tb or posedge rx_rst_tb) begin
    if (rx_rst_tb) begin
      state_q         <= StUnlocked;
      sh_cnt_q        <= '0;
      inv_cnt_q       <= '0;
      slip_cnt_q      <= '0;
      since_cnt_q     <= '0;
      armed_q         <= 1'b0;
      bitslip         <= 1'b0;
      block_lock      <= 1'b0;
      lock_loss_count <= '0;
      hdrs_to_unlock  <= '0;
    end else begin
      case (state_q)
        StUnlocked: begin
          if (hdr_valid) begin
            if (hdr_ok) begin
              if (sh_nxt == 7'd64 && inv_cnt_q == 5'd0) begin
                state_q     <= StLocked;
                block_lock  <= 1'b1;
                sh_cnt_q    <= '0;
                inv_cnt_q   <= '0;
                since_cnt_q <= '0;
                armed_q     <= 1'b1;
              end else begin
                sh_cnt_q <= sh_nxt;
              end
            end else begin
              state_q    <= StSlip;
              bitslip    <= 1'b1;
              slip_cnt_q <= '0;
              sh_cnt_q   <= '0;
              inv_cnt_q  <= '0;
            end
          end
        end
        StSlip: begin
          // Headers are ignored for the whole pulse plus blanking interval.
          if (slip_cnt_q == SlipLastCnt) begin
            state_q <= StUnlocked;
            bitslip <= 1'b0;
          end else begin
            if (slip_cnt_q == HighLastCnt) begin
              bitslip <= 1'b0;
            end
            slip_cnt_q <= slip_cnt_q + 16'd1;
          end
        end
        StLocked: begin
          if (hdr_valid) begin
            since_cnt_q <= since_nxt;
            // Loss of lock wins over the end-of-group clear.
            if (inv_nxt == 5'd16) begin
              state_q         <= StSlip;
              block_lock      <= 1'b0;
              bitslip         <= 1'b1;
              slip_cnt_q      <= '0;
              sh_cnt_q        <= '0;
              inv_cnt_q       <= '0;
              lock_loss_count <= (lock_loss_count == 8'hFF) ? 8'hFF : lock_loss_count + 8'd1;
              hdrs_to_unlock  <= since_nxt;
            end else if (sh_nxt == 7'd64) begin
              sh_cnt_q  <= '0;
              inv_cnt_q <= '0;
            end else begin
              sh_cnt_q  <= sh_nxt;
              inv_cnt_q <= inv_nxt;
            end
          end
        end
        default: begin
          state_q <= StUnlocked;
        end
      endcase
    end
  end

  // Window statistics count every qualified header once armed, whatever the lock state.
  always_ff @(posedge rx_clk_tb or posedge rx_rst_tb) begin
    if (rx_rst_tb) begin
      win_v_cnt_q <= '0;
      win_i_cnt_q <= '0;
      win_valid   <= '0;
      win_invalid <= '0;
      window_done <= 1'b0;
    end else begin
      window_done <= 1'b0;
      if (armed_q && hdr_valid) begin
        if (win_sum == WindowLen) begin
          win_valid   <= win_v_nxt;
          win_invalid <= win_i_nxt;
          window_done <= 1'b1;
          win_v_cnt_q <= '0;
          win_i_cnt_q <= '0;
        end else begin
          win_v_cnt_q <= win_v_nxt;
          win_i_cnt_q <= win_i_nxt;
        end
      end
    end
  end

endmodule

// File: doc/rx_hdr_lock_mon.md
RX_HDR_LOCK_MON -- requirements
Module: rx_hdr_lock_mon

Interface
REQ-001 SHALL have parameter HDR_WIDTH, default 2, sync header width.
REQ-002 SHALL have parameter BITSLIP_HIGH_CYCLES, default 1, bitslip pulse width in cycles.
REQ-003 SHALL have parameter BITSLIP_LOW_CYCLES, default 8, post-slip blanking cycles.
REQ-004 SHALL have parameter WINDOW, default 500, headers per statistics window.
REQ-005 SHALL have port rx_clk_tb  input  1  RX clock; all logic on its rising edge.
REQ-006 SHALL have port rx_rst_tb  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port hdr_valid  input  1  rx_hdr qualifies this cycle.
REQ-008 SHALL have port rx_hdr  input  HDR_WIDTH  received 64b/66b sync header.
REQ-009 SHALL have port bitslip  output  1  slip request to SERDES.
REQ-010 SHALL have port block_lock  output  1  block lock status.
REQ-011 SHALL have port lock_loss_count  output  8  lock-loss events, saturating at 255.
REQ-012 SHALL have port hdrs_to_unlock  output  16  headers from lock acquisition to most recent lock loss.
REQ-013 SHALL have port win_valid  output  16  valid headers in last completed window.
REQ-014 SHALL have port win_invalid  output  16  invalid headers in last completed window.
REQ-015 SHALL have port window_done  output  1  one-cycle pulse when win_* update.

Function
REQ-016 SHALL classify a header as valid if 2'b01 or 2'b10, invalid if 2'b00 or 2'b11; headers ignored when hdr_valid=0.
REQ-017 SHALL implement FSM states UNLOCKED, SLIP, LOCKED with a 7-bit sh_cnt and 5-bit inv_cnt.
REQ-018 UNLOCKED: valid header -> sh_cnt+1; sh_cnt reaching 64 with inv_cnt=0 -> LOCKED, block_lock=1 on next edge, counters cleared.
REQ-019 UNLOCKED: invalid header -> SLIP, counters cleared.
REQ-020 SLIP: bitslip=1 for BITSLIP_HIGH_CYCLES cycles, then 0 for BITSLIP_LOW_CYCLES cycles ignoring headers, then UNLOCKED.
REQ-021 LOCKED: every header -> sh_cnt+1; invalid -> inv_cnt+1.
REQ-022 LOCKED: inv_cnt reaching 16 -> SLIP, block_lock=0 on next edge, lock_loss_count+1 (saturating), hdrs_to_unlock latched.
REQ-023 LOCKED: sh_cnt reaching 64 with inv_cnt<16 -> both counters cleared, stay LOCKED.
REQ-024 If 16th invalid and 64th header coincide, loss of lock SHALL take priority.
REQ-025 A 16-bit since-lock counter SHALL clear on lock acquisition, increment per qualified header while LOCKED, and saturate at 65535; hdrs_to_unlock SHALL take its value including the header causing loss.
REQ-026 Window counters SHALL start only after the first lock acquisition since reset, then run continuously regardless of later lock state.
REQ-027 When valid+invalid in window reaches WINDOW: win_valid/win_invalid SHALL latch the totals, window_done SHALL pulse 1 cycle, counters SHALL restart at 0 on the same edge.
REQ-028 Outputs SHALL be registered; latency from header sample to block_lock/bitslip change is 1 cycle.

Reset
REQ-029 On rx_rst_tb=1 immediately: state UNLOCKED, bitslip=0, block_lock=0, window_done=0, all counters and outputs 0, window-armed flag cleared.
REQ-030 Reset asserted mid-SLIP or mid-LOCKED SHALL abort immediately with no residual bitslip pulse after release.
REQ-031 After reset release, first qualified header SHALL be sampled on the first rising edge.

Verification
REQ-032 64 consecutive 2'b10 headers after reset -> block_lock=1 one cycle after 64th; 63 -> block_lock stays 0.
REQ-033 While UNLOCKED, one 2'b11 header -> bitslip high 1 cycle, low 8 cycles with headers ignored, then lock acquisition restarts from 0.
REQ-034 While LOCKED, 15 invalid in a 64-header group -> stays locked; 16 invalid -> block_lock=0, lock_loss_count=1, hdrs_to_unlock equal to headers sent since lock.
REQ-035 Lock, then 500 headers with exactly 80 invalid spread under 16 per 64 -> window_done pulse, win_valid=420, win_invalid=80.
REQ-036 Assert rx_rst_tb asynchronously during LOCKED -> all outputs 0 without waiting for a clock; relock needs 64 fresh valid headers.
REQ-037 Force 256 lock-loss events -> lock_loss_count holds at 255.
